scan_oracle_ctrl: RTL and testbench
===================================

# scan_oracle_ctrl

Scan-access controller that drives a locked or benchmark sequential netlist as an oracle. It accepts a query containing a flop state, a primary-input vector and a capture-cycle count, and shifts the state into the netlist's scan chain. It then runs functional capture cycles, shifts the resulting state back out and returns it with the primary outputs. It is the driving/reading end of the scan chain inserted into the gate-level netlists under attack, and sits between the attack host interface and the netlist wrapper.

## Interface
- CHAIN_LEN, 3, number of flops in the scan chain (≥1)
- PI_W, 4, primary-input width
- PO_W, 1, primary-output width
- CNT_W, 8, width of capture-cycle count
- CLK  input  1  single clock; all state changes on rising edge
- RST  input  1  reset, asynchronous, active-high
- req_valid  input  1  query valid
- req_ready  output  1  controller can accept a query
- req_state  input  CHAIN_LEN  state to load, bit k → chain position k
- req_pi  input  PI_W  primary inputs applied during capture
- req_cycles  input  CNT_W  number of functional capture cycles (0 allowed)
- rsp_valid  output  1  response valid
- rsp_ready  input  1  host accepts response
- rsp_state  output  CHAIN_LEN  state read back, bit k = chain position k
- rsp_po  output  PO_W  primary outputs sampled at end of capture
- scan_en  output  1  chain in shift mode
- scan_in  output  1  serial data into chain (enters at position CHAIN_LEN-1)
- scan_out  input  1  serial data from chain (position 0)
- func_en  output  1  functional clock enable for netlist flops
- pi_out  output  PI_W  primary inputs to netlist
- po_in  input  PO_W  primary outputs from netlist

## Operation
- FSM states: IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, latch req_state, req_pi and req_cycles → SHIFT_IN. Internal shift counter = 0.
- SHIFT_IN: scan_en=1, func_en=0. Shift order is LSB first: the cycle with counter i drives scan_in=req_state[i], so that after CHAIN_LEN shifts position k holds req_state[k]. After CHAIN_LEN cycles, go to CAPTURE if latched count ≠0, else SHIFT_OUT.
- CAPTURE: scan_en=0, func_en=1 for exactly req_cycles cycles. po_in is sampled into rsp_po on the edge ending the last capture cycle. Then → SHIFT_OUT.
- SHIFT_OUT: scan_en=1, func_en=0, scan_in=0. In the shift cycle with counter j, sample scan_out into rsp_state[j]. For count 0, sample po_in into rsp_po on the first SHIFT_OUT edge, before any shift has occurred. After CHAIN_LEN cycles → RESP.
- RESP: rsp_valid=1. rsp_state and rsp_po are held stable. On rsp_ready → IDLE.
- pi_out drives the latched req_pi from acceptance until leaving RESP. It is 0 in IDLE.
- A new request is never accepted while not IDLE. req_valid outside IDLE is ignored.
- Counters are sized ceil(log2(CHAIN_LEN+1)) and CNT_W. No wrap is possible; the capture counter counts down from the latched value.

## Timing
- Reset (async assert, sync deassert assumed external): state=IDLE, req_ready=1, rsp_valid=0, scan_en=0, func_en=0, scan_in=0, pi_out=0, rsp_state=0, rsp_po=0, all counters 0.
- RST asserted mid-query aborts immediately. The chain contents are then undefined and it is the host's job to re-query.
- Latency: acceptance edge E. SHIFT_IN occupies cycles E+1..E+L (L=CHAIN_LEN), followed by N capture cycles and L shift-out cycles. rsp_valid rises 2L+N cycles after E, i.e. visible in cycle E+2L+N+1.
- If rsp_ready=1 when rsp_valid rises, the response lasts one cycle and req_ready is 1 in the next cycle. Back-to-back throughput is 2L+N+2 cycles per query.
- scan_en and func_en are never both 1.

## Test plan
- Reset mid-SHIFT_OUT (RST high for 1 cycle) → all outputs at reset values next cycle; a following query completes normally.
- Loopback chain model (capture = hold), L=3: req_state=3'b101, req_cycles=0 → rsp_state=3'b101, rsp_valid at E+7, scan_en high exactly 6 cycles.
- Inverting chain model (each capture complements state): req_state=3'b110, req_cycles=1 → 3'b001. With req_cycles=2 → 3'b110; func_en high exactly 2 cycles.
- s27 netlist, chain order G5,G6,G7 = positions 0,1,2, pi_out[3:0]=G3..G0, po_in=G17: state 000, pi 0000, cycles 1 → rsp_state 000, rsp_po 1.
- s27, state 000, pi 0001, cycles 1 → rsp_state 001, rsp_po 1.
- Backpressure: hold rsp_ready=0 for 5 cycles → rsp_valid, rsp_state and rsp_po stable. req_valid pulsed during that time is not accepted (req_ready=0).

Source files
------------

// File: rtl/scan_oracle_ctrl.sv
// Scan-access oracle controller: loads a flop state through the scan chain, runs
// N functional capture cycles, shifts the resulting state back out and returns it.
`timescale 1ns/1ps
module scan_oracle_ctrl #(
   parameter int unsigned CHAIN_LEN = 3,
   parameter int unsigned PI_W      = 4,
   parameter int unsigned PO_W      = 1,
   parameter int unsigned CNT_W     = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [CHAIN_LEN-1:0] req_state,
   input  logic [PI_W-1:0]      req_pi,
   input  logic [CNT_W-1:0]     req_cycles,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [CHAIN_LEN-1:0] rsp_state,
   output logic [PO_W-1:0]      rsp_po,
   output logic                 scan_en,
   output logic                 scan_in,
   input  logic                 scan_out,
   output logic                 func_en,
   output logic [PI_W-1:0]      pi_out,
   input  logic [PO_W-1:0]      po_in
);

   localparam int unsigned CW = $clog2(CHAIN_LEN + 1);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] SHIFT_IN  = 3'd1;
   localparam logic [2:0] CAPTURE   = 3'd2;
   localparam logic [2:0] SHIFT_OUT = 3'd3;
   localparam logic [2:0] RESP      = 3'd4;

   logic [2:0]           state, state_d;
   logic [CW-1:0]        cnt, cnt_d;
   logic [CNT_W-1:0]     cap, cap_d;
   logic                 nocap, nocap_d;
   logic [CHAIN_LEN-1:0] st_q, st_d;
   logic [PI_W-1:0]      pi_q, pi_d;
   logic [CHAIN_LEN-1:0] rsp_state_d;
   logic [PO_W-1:0]      rsp_po_d;
   logic                 req_ready_d, rsp_valid_d, scan_en_d, func_en_d, scan_in_d;
   logic [PI_W-1:0]      pi_out_d;

   // Next-state and next-output logic; outputs are decoded from the next state so they register cleanly.
   always_comb begin
      state_d     = state;
      cnt_d       = cnt;
      cap_d       = cap;
      nocap_d     = nocap;
      st_d        = st_q;
      pi_d        = pi_q;
      rsp_state_d = rsp_state;
      rsp_po_d    = rsp_po;

      case (state)
         IDLE: begin
            if (req_valid && req_ready) begin
               st_d    = req_state;
               pi_d    = req_pi;
               cap_d   = req_cycles;
               nocap_d = (req_cycles == '0);
               cnt_d   = '0;
               state_d = SHIFT_IN;
            end
         end
         SHIFT_IN: begin
            if (cnt == CW'(CHAIN_LEN - 1)) begin
               cnt_d   = '0;
               state_d = (cap != '0) ? CAPTURE : SHIFT_OUT;
            end else begin
               cnt_d = cnt + CW'(1);
            end
         end
         CAPTURE: begin
            cap_d = cap - CNT_W'(1);
            if (cap == CNT_W'(1)) begin
               rsp_po_d = po_in;
               state_d  = SHIFT_OUT;
            end
         end
         SHIFT_OUT: begin
            for (int k = 0; k < CHAIN_LEN; k++) begin
               if (cnt == CW'(k)) rsp_state_d[k] = scan_out;
            end
            // With no capture, outputs are sampled before the first shift disturbs the chain.
            if (nocap && cnt == '0) rsp_po_d = po_in;
            if (cnt == CW'(CHAIN_LEN - 1)) begin
               cnt_d   = '0;
               state_d = RESP;
            end else begin
               cnt_d = cnt + CW'(1);
            end
         end
         RESP: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      req_ready_d = (state_d == IDLE);
      rsp_valid_d = (state_d == RESP);
      scan_en_d   = (state_d == SHIFT_IN) || (state_d == SHIFT_OUT);
      func_en_d   = (state_d == CAPTURE);
      pi_out_d    = (state_d != IDLE) ? pi_d : '0;
      scan_in_d   = 1'b0;
      for (int k = 0; k < CHAIN_LEN; k++) begin
         if (state_d == SHIFT_IN && cnt_d == CW'(k)) scan_in_d = st_d[k];
      end
   end

   // State, datapath and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         cap       <= '0;
         nocap     <= 1'b0;
         st_q      <= '0;
         pi_q      <= '0;
         rsp_state <= '0;
         rsp_po    <= '0;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         scan_en   <= 1'b0;
         func_en   <= 1'b0;
         scan_in   <= 1'b0;
         pi_out    <= '0;
      end else begin
         state     <= state_d;
         cnt       <= cnt_d;
         cap       <= cap_d;
         nocap     <= nocap_d;
         st_q      <= st_d;
         pi_q      <= pi_d;
         rsp_state <= rsp_state_d;
         rsp_po    <= rsp_po_d;
         req_ready <= req_ready_d;
         rsp_valid <= rsp_valid_d;
         scan_en   <= scan_en_d;
         func_en   <= func_en_d;
         scan_in   <= scan_in_d;
         pi_out    <= pi_out_d;
      end
   end

endmodule

// File: tb/tb_scan_oracle_ctrl.sv
// Bench for scan_oracle_ctrl: a behavioural netlist on the chain, a queue of expected
// responses filled at acceptance, and a monitor that checks each response it presents.
`timescale 1ns/1ps
module tb_scan_oracle_ctrl;
   localparam int unsigned L     = 3;
   localparam int unsigned PI_W  = 4;
   localparam int unsigned PO_W  = 1;
   localparam int unsigned CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             req_valid = 1'b0;
   logic             req_ready;
   logic [L-1:0]     req_state = '0;
   logic [PI_W-1:0]  req_pi = '0;
   logic [CNT_W-1:0] req_cycles = '0;
   logic             rsp_valid;
   logic             rsp_ready = 1'b1;
   logic [L-1:0]     rsp_state;
   logic [PO_W-1:0]  rsp_po;
   logic             scan_en, scan_in, scan_out, func_en;
   logic [PI_W-1:0]  pi_out;
   logic [PO_W-1:0]  po_in;

   scan_oracle_ctrl #(.CHAIN_LEN(L), .PI_W(PI_W), .PO_W(PO_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_state(req_state),
      .req_pi(req_pi), .req_cycles(req_cycles),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_state(rsp_state), .rsp_po(rsp_po),
      .scan_en(scan_en), .scan_in(scan_in), .scan_out(scan_out), .func_en(func_en),
      .pi_out(pi_out), .po_in(po_in)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [L-1:0]    st;
      logic [PO_W-1:0] po;
      int              n;
      int              acc;
   } exp_t;
   exp_t q[$];

   int              mode = 0;     // 0 loopback/hold, 1 inverting, 2 s27
   int              rdy_mode = 0; // 0 always ready, 1 never, 2 random
   logic [PI_W-1:0] act_pi = '0;
   logic [L-1:0]    chain = '0;

   // s27: returns {G17, G7', G6', G5'} with G5,G6,G7 = s[0..2], G0..G3 = pi[0..3]
   function automatic logic [3:0] s27(input logic [2:0] s, input logic [3:0] pi);
      logic g14, g8, g12, g15, g16, g9, g11, g10, g13;
      g14 = ~pi[0];
      g12 = ~(pi[1] | s[2]);
      g8  = g14 & s[1];
      g15 = g12 | g8;
      g16 = pi[3] | g8;
      g9  = ~(g16 & g15);
      g11 = ~(s[0] | g9);
      g10 = ~(g14 | g11);
      g13 = ~(pi[2] | g12);
      return {~g11, g13, g11, g10};
   endfunction

   function automatic logic [L-1:0] nl_next(input int m, input logic [L-1:0] s, input logic [PI_W-1:0] pi);
      logic [3:0] r;
      r = s27(s, pi);
      if (m == 0) return s;
      if (m == 1) return ~s;
      return r[2:0];
   endfunction

   function automatic logic [PO_W-1:0] nl_po(input int m, input logic [L-1:0] s, input logic [PI_W-1:0] pi);
      logic [3:0] r;
      r = s27(s, pi);
      if (m == 2) return PO_W'(r[3]);
      return PO_W'(^s ^ pi[0]);
   endfunction

   // Expected response: apply the netlist function n times; outputs seen before the last step.
   function automatic exp_t ref_model(input int m, input logic [L-1:0] s, input logic [PI_W-1:0] pi, input int n);
      exp_t e;
      e.st  = s;
      e.po  = nl_po(m, s, pi);
      e.n   = n;
      e.acc = 0;
      for (int i = 0; i < n; i++) begin
         e.po = nl_po(m, e.st, pi);
         e.st = nl_next(m, e.st, pi);
      end
      return e;
   endfunction

   // Netlist under attack: scan shift toward position 0, functional update when enabled.
   always @(posedge clk) begin
      if (scan_en)      chain <= {scan_in, chain[L-1:1]};
      else if (func_en) chain <= nl_next(mode, chain, pi_out);
   end
   assign scan_out = chain[0];
   assign po_in    = nl_po(mode, chain, pi_out);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_ctl"}, 32'({req_ready, rsp_valid, scan_en, func_en, scan_in}), 32'b10000);
      chk({tag, "_pi_out"}, 32'(pi_out), 0);
      chk({tag, "_rsp_state"}, 32'(rsp_state), 0);
      chk({tag, "_rsp_po"}, 32'(rsp_po), 0);
   endtask

   initial forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0)      rsp_ready = 1'b1;
      else if (rdy_mode == 1) rsp_ready = 1'b0;
      else                    rsp_ready = ($urandom_range(0, 2) != 0);
   end

   // Monitor: pops on each response presentation, checks holds and invariants every cycle.
   logic            prev_valid = 1'b0, prev_hs = 1'b0;
   logic [L-1:0]    held_st = '0;
   logic [PO_W-1:0] held_po = '0;
   int              se_cnt = 0, fe_cnt = 0;
   initial forever begin
      @(negedge clk);
      if (rst) begin
         prev_valid = 1'b0; prev_hs = 1'b0; se_cnt = 0; fe_cnt = 0;
      end else begin
         if (scan_en && func_en) chk("scan_func_exclusive", 32'({scan_en, func_en}), 32'b00);
         chk("pi_out", 32'(pi_out), req_ready ? 0 : 32'(act_pi));
         if (prev_hs) chk("idle_after_rsp", 32'({req_ready, rsp_valid}), 32'b10);
         if (rsp_valid && !prev_valid) begin
            if (q.size() == 0) begin
               chk("unexpected_rsp", 32'(rsp_valid), 0);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("rsp_state", 32'(rsp_state), 32'(e.st));
               chk("rsp_po", 32'(rsp_po), 32'(e.po));
               chk("latency", 32'(cyc - e.acc), 32'(1 + 2 * L + e.n));
               chk("scan_en_cycles", 32'(se_cnt), 32'(2 * L));
               chk("func_en_cycles", 32'(fe_cnt), 32'(e.n));
            end
            held_st = rsp_state; held_po = rsp_po;
            se_cnt = 0; fe_cnt = 0;
         end else if (rsp_valid) begin
            chk("rsp_state_hold", 32'(rsp_state), 32'(held_st));
            chk("rsp_po_hold", 32'(rsp_po), 32'(held_po));
         end
         if (scan_en) se_cnt++;
         if (func_en) fe_cnt++;
         prev_hs    = rsp_valid && rsp_ready;
         prev_valid = rsp_valid;
      end
   end

   task automatic do_query(input int m, input logic [L-1:0] s, input logic [PI_W-1:0] pi,
                           input int n, output int acc);
      exp_t e;
      int   w;
      acc = -1;
      @(negedge clk);
      req_valid = 1'b1; req_state = s; req_pi = pi; req_cycles = CNT_W'(n);
      w = 0;
      while (!req_ready && w < 1000) begin
         @(negedge clk);
         w++;
      end
      if (!req_ready) begin
         chk("accept_timeout", 32'(req_ready), 1);
         req_valid = 1'b0;
      end else begin
         mode   = m;
         act_pi = pi;
         e      = ref_model(m, s, pi, n);
         e.acc  = cyc;
         acc    = cyc;
         q.push_back(e);
         @(posedge clk);
         #1;
         req_valid  = 1'b0;
         req_state  = L'($urandom);
         req_pi     = PI_W'($urandom);
         req_cycles = CNT_W'($urandom);
      end
   endtask

   task automatic wait_done();
      int w;
      w = 0;
      do begin
         @(negedge clk);
         w++;
      end while (!(q.size() == 0 && req_ready && !rsp_valid) && w < 2000);
      if (w >= 2000) chk("done_timeout", 32'(q.size()), 0);
   endtask

   initial begin
      int a1, a2, w;
      #200000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int a1, a2, w;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_outs("in_reset");
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk_reset_outs("after_reset");

      // loopback, inverting and s27 directed cases
      do_query(0, 3'b101, 4'b0011, 0, a1); wait_done();
      do_query(1, 3'b110, 4'b0000, 1, a1); wait_done();
      do_query(1, 3'b110, 4'b0000, 2, a1); wait_done();
      do_query(2, 3'b000, 4'b0000, 1, a1); wait_done();
      do_query(2, 3'b000, 4'b0001, 1, a1); wait_done();

      // back-to-back throughput with an always-ready host
      do_query(0, 3'b011, 4'b1010, 4, a1);
      do_query(2, 3'b111, 4'b0101, 1, a2);
      chk("throughput", 32'(a2 - a1), 32'(2 * L + 4 + 2));
      wait_done();

      // backpressure: response held for 5 cycles while a request is offered
      rdy_mode = 1;
      do_query(1, 3'b011, 4'b0110, 3, a1);
      w = 0;
      while (!rsp_valid && w < 100) begin @(negedge clk); w++; end
      chk("bp_rsp_valid", 32'(rsp_valid), 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         req_valid = 1'b1;
         req_state = L'($urandom);
         chk("bp_req_ready", 32'(req_ready), 0);
         chk("bp_rsp_valid_held", 32'(rsp_valid), 1);
      end
      @(negedge clk);
      req_valid = 1'b0;
      rdy_mode  = 0;
      wait_done();

      // reset in the middle of shift-out, then a normal query
      do_query(1, 3'b101, 4'b1111, 2, a1);
      repeat (L + 2 + 1) @(posedge clk);
      #1;
      chk("mid_shift_out", 32'({scan_en, func_en}), 32'b10);
      rst = 1'b1;
      q.delete();
      #1;
      chk_reset_outs("async_reset");
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk_reset_outs("after_mid_reset");
      do_query(2, 3'b010, 4'b1001, 3, a1); wait_done();

      // randomized queries with random host backpressure
      rdy_mode = 2;
      for (int i = 0; i < 40; i++) begin
         do_query(int'($urandom_range(0, 2)), L'($urandom), PI_W'($urandom),
                  int'($urandom_range(0, 12)), a1);
      end
      wait_done();
      rdy_mode = 0;
      repeat (2) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
